// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: two-stage F0/F1 fetch with BTB lookup, 2-bit BHT direction
// prediction and execute-stage redirect on mispredict.
module fetch_pc_gen #(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  BHT_DEPTH = 16,
  parameter int                  BHT_PTR   = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  output logic                lookup_valid,
  output logic [PC_WIDTH-1:0] lookup_pc,
  input  logic                hit,
  input  logic [PC_WIDTH-1:0] target_pc,
  output logic                update_valid,
  output logic [PC_WIDTH-1:0] update_pc,
  output logic [PC_WIDTH-1:0] update_target,
  input  logic                ex_valid,
  input  logic                ex_is_branch,
  input  logic                ex_taken,
  input  logic                ex_pred_taken,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic [PC_WIDTH-1:0] ex_target,
  input  logic [PC_WIDTH-1:0] ex_pred_target,
  output logic                out_valid,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [PC_WIDTH-1:0] out_pred_target,
  output logic                out_pred_taken,
  output logic                flush
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] f1_pc;
  logic                f1_valid;
  logic [1:0]          bht [BHT_DEPTH];
  logic [BHT_PTR-1:0]  rd_idx;
  logic [BHT_PTR-1:0]  wr_idx;
  logic                ex_branch;
  logic                mispredict;
  logic                pred;

  assign rd_idx    = f1_pc[BHT_PTR+1:2];
  assign wr_idx    = ex_pc[BHT_PTR+1:2];
  assign ex_branch = ex_valid & ex_is_branch;

  // A taken branch is also wrong if it went somewhere other than the predicted target.
  assign mispredict = ex_branch &
                      ((ex_taken != ex_pred_taken) | (ex_taken & (ex_target != ex_pred_target)));

  assign pred            = f1_valid & hit & bht[rd_idx][1];
  assign lookup_valid    = reset & ~stall;
  assign lookup_pc       = pc;
  assign out_valid       = f1_valid & ~mispredict;
  assign out_pc          = f1_pc;
  assign out_pred_taken  = pred;
  assign out_pred_target = pred ? target_pc : f1_pc + PC_STEP;
  assign flush           = mispredict;
  assign update_valid    = ex_branch & ex_taken;
  assign update_pc       = ex_pc;
  assign update_target   = ex_target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      f1_pc    <= RESET_PC;
      f1_valid <= 1'b0;
    end else if (mispredict) begin
      pc       <= ex_taken ? ex_target : ex_pc + PC_STEP;
      f1_valid <= 1'b0;
    end else if (!stall) begin
      f1_pc <= pc;
      if (pred) begin
        // Sequential fetch already issued behind the predicted branch is dropped.
        pc       <= target_pc;
        f1_valid <= 1'b0;
      end else begin
        pc       <= pc + PC_STEP;
        f1_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (ex_branch) begin
      if (ex_taken) begin
        if (bht[wr_idx] != 2'b11) bht[wr_idx] <= bht[wr_idx] + 2'b01;
      end else begin
        if (bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed vector table, hand-written corner sequences and
// random stimulus, all checked against a cycle-level reference model.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, hit, ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] target_pc, ex_pc, ex_target, ex_pred_target;
  logic        lookup_valid, update_valid, out_valid, out_pred_taken, flush;
  logic [31:0] lookup_pc, update_pc, update_target, out_pc, out_pred_target;

  fetch_pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .hit(hit), .target_pc(target_pc),
    .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_target(ex_pred_target),
    .out_valid(out_valid), .out_pc(out_pc), .out_pred_target(out_pred_target),
    .out_pred_taken(out_pred_taken), .flush(flush)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int unsigned m_pc, m_f1pc;
  bit          m_f1v;
  int          m_bht [16];

  // DUT outputs sampled by the last step()
  logic        s_lv, s_ov, s_opt, s_flush, s_uv;
  logic [31:0] s_lpc, s_opc, s_optgt, s_upc, s_utgt;

  typedef struct {
    bit          stall;
    bit          exv;
    bit          ext;
    bit          expt;
    logic [31:0] expc;
    logic [31:0] extgt;
    bit          e_lv;
    logic [31:0] e_lpc;
    bit          e_ov;
    logic [31:0] e_opc;
    bit          e_flush;
  } vec_t;

  vec_t vecs [12];

  task automatic chk_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    stall = 1'b0; hit = 1'b0; target_pc = '0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
    ex_pc = '0; ex_target = '0; ex_pred_target = '0;
  endtask

  task automatic m_reset();
    m_pc = 0; m_f1pc = 0; m_f1v = 1'b0;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
  endtask

  function automatic bit m_mis();
    return ex_valid && ex_is_branch &&
           (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
  endfunction

  function automatic bit m_pred();
    return m_f1v && hit && (m_bht[(m_f1pc >> 2) & 15] >= 2);
  endfunction

  // One clock: sample and check at negedge, advance the model at posedge.
  task automatic step();
    bit mis, pr;
    int idx;
    @(negedge clk);
    s_lv = lookup_valid; s_lpc = lookup_pc; s_ov = out_valid; s_opc = out_pc;
    s_opt = out_pred_taken; s_optgt = out_pred_target; s_flush = flush;
    s_uv = update_valid; s_upc = update_pc; s_utgt = update_target;
    mis = m_mis();
    pr  = m_pred();
    chk_b("lookup_valid", s_lv, !stall);
    chk_w("lookup_pc", s_lpc, m_pc);
    chk_b("out_valid", s_ov, m_f1v && !mis);
    chk_b("out_pred_taken", s_opt, pr);
    if (m_f1v) begin
      chk_w("out_pc", s_opc, m_f1pc);
      chk_w("out_pred_target", s_optgt, pr ? target_pc : m_f1pc + 32'd4);
    end
    chk_b("flush", s_flush, mis);
    chk_b("update_valid", s_uv, ex_valid && ex_is_branch && ex_taken);
    if (ex_valid && ex_is_branch && ex_taken) begin
      chk_w("update_pc", s_upc, ex_pc);
      chk_w("update_target", s_utgt, ex_target);
    end
    @(posedge clk);
    if (ex_valid && ex_is_branch) begin
      idx = int'(ex_pc[5:2]);
      if (ex_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else          m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
    end
    if (mis) begin
      m_pc  = ex_taken ? ex_target : ex_pc + 32'd4;
      m_f1v = 1'b0;
    end else if (!stall) begin
      if (pr) begin
        m_pc  = target_pc;
        m_f1v = 1'b0;
      end else begin
        m_f1pc = m_pc;
        m_f1v  = 1'b1;
        m_pc   = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    //          stall exv ext expt expc   extgt  lv lpc    ov opc    flush
    vecs[0]  = '{0, 0, 0, 0, 32'h0,  32'h0, 1, 32'h00, 0, 32'h00, 0};
    vecs[1]  = '{0, 0, 0, 0, 32'h0,  32'h0, 1, 32'h04, 1, 32'h00, 0};
    vecs[2]  = '{0, 0, 0, 0, 32'h0,  32'h0, 1, 32'h08, 1, 32'h04, 0};
    vecs[3]  = '{0, 0, 0, 0, 32'h0,  32'h0, 1, 32'h0C, 1, 32'h08, 0};
    vecs[4]  = '{1, 0, 0, 0, 32'h0,  32'h0, 0, 32'h10, 1, 32'h0C, 0};
    vecs[5]  = '{1, 0, 0, 0, 32'h0,  32'h0, 0, 32'h10, 1, 32'h0C, 0};
    vecs[6]  = '{1, 0, 0, 0, 32'h0,  32'h0, 0, 32'h10, 1, 32'h0C, 0};
    vecs[7]  = '{0, 0, 0, 0, 32'h0,  32'h0, 1, 32'h10, 1, 32'h0C, 0};
    vecs[8]  = '{0, 0, 0, 0, 32'h0,  32'h0, 1, 32'h14, 1, 32'h10, 0};
    vecs[9]  = '{1, 1, 0, 1, 32'h40, 32'h0, 0, 32'h18, 0, 32'h14, 1};
    vecs[10] = '{0, 0, 0, 0, 32'h0,  32'h0, 1, 32'h44, 0, 32'h00, 0};
    vecs[11] = '{0, 0, 0, 0, 32'h0,  32'h0, 1, 32'h48, 1, 32'h44, 0};

    idle();
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    chk_b("rst_lookup_valid", lookup_valid, 1'b0);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_out_pred_taken", out_pred_taken, 1'b0);
    chk_w("rst_lookup_pc", lookup_pc, 32'h0);

    // sequential fetch, 3-cycle stall, mispredict during stall
    do_reset();
    for (int i = 0; i < 12; i++) begin
      stall = vecs[i].stall;
      ex_valid = vecs[i].exv; ex_is_branch = vecs[i].exv;
      ex_taken = vecs[i].ext; ex_pred_taken = vecs[i].expt;
      ex_pc = vecs[i].expc; ex_target = vecs[i].extgt; ex_pred_target = vecs[i].extgt;
      step();
      chk_b($sformatf("vec%0d_lv", i), s_lv, vecs[i].e_lv);
      chk_w($sformatf("vec%0d_lpc", i), s_lpc, vecs[i].e_lpc);
      chk_b($sformatf("vec%0d_ov", i), s_ov, vecs[i].e_ov);
      if (vecs[i].e_ov) chk_w($sformatf("vec%0d_opc", i), s_opc, vecs[i].e_opc);
      chk_b($sformatf("vec%0d_flush", i), s_flush, vecs[i].e_flush);
    end

    // trained BTB/BHT: predicted-taken fetch redirects and squashes sequential fetch
    do_reset();
    ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pred_taken = 0;
    ex_pc = 32'h20; ex_target = 32'h80; ex_pred_target = 32'h0;
    step(); chk_b("r032_flush1", s_flush, 1'b1);
    step(); chk_b("r032_flush2", s_flush, 1'b1);
    ex_pc = 32'h100; ex_target = 32'h20;
    step();
    idle();
    step(); chk_w("r032_lpc20", s_lpc, 32'h20);
    hit = 1; target_pc = 32'h80;
    step();
    chk_b("r032_pred", s_opt, 1'b1);
    chk_w("r032_opc", s_opc, 32'h20);
    chk_w("r032_ptgt", s_optgt, 32'h80);
    hit = 0; target_pc = 32'h0;
    step();
    chk_w("r032_redirect", s_lpc, 32'h80);
    chk_b("r032_squash", s_ov, 1'b0);
    step();
    chk_b("r032_ov80", s_ov, 1'b1);
    chk_w("r032_opc80", s_opc, 32'h80);

    // reset asserted while a prediction is pending
    ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pred_taken = 0;
    ex_pc = 32'h100; ex_target = 32'h20; ex_pred_target = 32'h0;
    step();
    idle();
    step();
    hit = 1; target_pc = 32'h80;
    @(negedge clk);
    chk_b("r035_pending", out_pred_taken, 1'b1);
    #1 reset = 1'b0;
    m_reset();
    #1;
    chk_b("r035_out_valid", out_valid, 1'b0);
    chk_b("r035_pred", out_pred_taken, 1'b0);
    chk_b("r035_lookup_valid", lookup_valid, 1'b0);
    hit = 0; target_pc = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    chk_w("r035_lpc", s_lpc, 32'h0);

    // counter saturation at 3 and 0
    do_reset();
    stall = 1; hit = 1; target_pc = 32'h200;
    ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pred_taken = 1;
    ex_pc = 32'h8; ex_target = 32'h300; ex_pred_target = 32'h300;
    repeat (4) step();
    ex_valid = 0; stall = 0;
    repeat (3) step();
    step();
    chk_w("r034_opc_hi", s_opc, 32'h8);
    chk_b("r034_sat_hi", s_opt, 1'b1);
    stall = 1; ex_valid = 1; ex_taken = 0; ex_pred_taken = 0;
    repeat (4) step();
    ex_pc = 32'h100; ex_taken = 1; ex_target = 32'h8; ex_pred_target = 32'h0;
    step();
    ex_valid = 0; stall = 0;
    step();
    step();
    chk_w("r034_opc_lo", s_opc, 32'h8);
    chk_b("r034_sat_lo", s_opt, 1'b0);

    // PC wraps past all-ones
    hit = 0;
    ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pred_taken = 0;
    ex_pc = 32'h100; ex_target = 32'hFFFF_FFFC; ex_pred_target = 32'h0;
    step();
    idle();
    step(); chk_w("wrap_lpc_top", s_lpc, 32'hFFFF_FFFC);
    step();
    chk_w("wrap_lpc_zero", s_lpc, 32'h0);
    chk_w("wrap_opc", s_opc, 32'hFFFF_FFFC);
    chk_w("wrap_ptgt", s_optgt, 32'h0);

    // random stimulus against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      stall          = ($urandom_range(0, 3) == 0);
      hit            = $urandom_range(0, 1) == 1;
      target_pc      = $urandom_range(0, 1023) << 2;
      ex_valid       = ($urandom_range(0, 2) == 0);
      ex_is_branch   = ($urandom_range(0, 3) != 0);
      ex_taken       = ($urandom_range(0, 2) != 0);
      ex_pred_taken  = $urandom_range(0, 1) == 1;
      ex_pc          = $urandom_range(0, 63) << 2;
      ex_target      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8
                                                    : ($urandom_range(0, 1023) << 2);
      ex_pred_target = ($urandom_range(0, 1) == 1) ? ex_target
                                                   : ($urandom_range(0, 1023) << 2);
      step();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameters: PC_WIDTH, 32, PC width; BHT_DEPTH, 16, branch history entries; BHT_PTR, 4, BHT index width; RESET_PC, 0, first fetch address.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; state forced to reset values while low.
REQ-004 stall  input  1  downstream back-pressure; holds fetch state.
REQ-005 lookup_valid  output  1  BTB lookup request.
REQ-006 lookup_pc  output  PC_WIDTH  BTB lookup address.
REQ-007 hit  input  1  BTB hit, registered one cycle after lookup.
REQ-008 target_pc  input  PC_WIDTH  BTB target, aligned with hit.
REQ-009 update_valid / update_pc / update_target  output  1/PC_WIDTH/PC_WIDTH  BTB write port.
REQ-010 ex_valid, ex_is_branch, ex_taken, ex_pred_taken  input  1 each  branch resolution from execute.
REQ-011 ex_pc, ex_target, ex_pred_target  input  PC_WIDTH each  resolved branch PC, actual target, predicted target.
REQ-012 out_valid  output  1  fetched PC valid for decode.
REQ-013 out_pc, out_pred_target  output  PC_WIDTH  fetched PC and predicted next PC.
REQ-014 out_pred_taken  output  1  prediction attached to out_pc.
REQ-015 flush  output  1  wrong-path squash to pipeline.

Function
REQ-016 Stage F0: register pc; lookup_valid = reset high & !stall; lookup_pc = pc.
REQ-017 Stage F1: registers f1_valid, f1_pc capture F0 when !stall; hit/target_pc pair with f1_pc.
REQ-018 BHT: BHT_DEPTH 2-bit saturating counters indexed by pc[BHT_PTR+1:2]; taken when bit[1]=1.
REQ-019 pred = f1_valid & hit & bht[f1_pc][1]; out_valid = f1_valid & !flush; out_pc = f1_pc; out_pred_taken = pred; out_pred_target = pred ? target_pc : f1_pc+4.
REQ-020 mispredict = ex_valid & ex_is_branch & (ex_taken != ex_pred_taken | (ex_taken & ex_target != ex_pred_target)); flush = mispredict, combinational.
REQ-021 Next-pc priority: mispredict -> (ex_taken ? ex_target : ex_pc+4), f1_valid<=0; else stall -> hold pc, f1; else pred -> target_pc, f1_valid<=0 (one-bubble squash of sequential fetch); else pc+4, f1_valid<=1.
REQ-022 Mispredict overrides stall in the same cycle.
REQ-023 PC arithmetic modulo 2^PC_WIDTH; pc+4 wraps from all-ones-minus-3 to 0 silently.
REQ-024 BHT update on ex_valid & ex_is_branch: taken increments, not-taken decrements, saturate at 3 and 0; independent of stall.
REQ-025 Same-cycle BHT read and update to same index: prediction uses old value; new value visible next cycle.
REQ-026 update_valid = ex_valid & ex_is_branch & ex_taken; update_pc = ex_pc; update_target = ex_target; combinational.
REQ-027 Non-branch ex_valid: no BHT, BTB or flush activity.

Reset
REQ-028 While reset low: pc=RESET_PC, f1_valid=0, all BHT counters=2'b01, out_valid=0, out_pred_taken=0, lookup_valid=0.
REQ-029 Reset asserted mid-operation discards in-flight F1 and pending redirect; first lookup after release uses RESET_PC.

Verification
REQ-030 Release reset, no branches, stall=0 -> lookup_pc 0,4,8,...; out_pc trails by one cycle; out_valid=1 from second cycle.
REQ-031 stall=1 for 3 cycles at pc=0x10 -> lookup_valid=0, pc and out_pc held, resume at 0x14.
REQ-032 Two taken resolutions ex_pc=0x20 ex_target=0x80 (mispredicted), then fetch 0x20 with hit=1 -> out_pred_taken=1, next lookup 0x80, fetch of 0x24 squashed.
REQ-033 ex mispredict ex_pc=0x40 ex_taken=0 during stall=1 -> flush=1 same cycle, next pc=0x44, out_valid=0 next cycle.
REQ-034 Four taken updates at one index -> counter saturates at 3; four not-taken -> saturates at 0; no wrap.
REQ-035 Assert reset low mid-stream with pending pred -> outputs at REQ-028 values immediately; post-release lookup_pc=RESET_PC.
